// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock by trial
// subtraction, with a start/busy/done handshake and divide-by-zero reporting.
module divider_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH:0]   r, r_n;
    logic [WIDTH-1:0] q, q_n;
    logic [WIDTH-1:0] dvsr, dvsr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             busy_n, done_n, dbz_n;
    logic [WIDTH-1:0] quotient_n, remainder_n;
    logic [WIDTH:0]   r_shift, t;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            r           <= r_n;
            q           <= q_n;
            dvsr        <= dvsr_n;
            cnt         <= cnt_n;
            busy        <= busy_n;
            done        <= done_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            div_by_zero <= dbz_n;
        end
    end

    // Next-state, iteration step and registered-output values
    always_comb begin
        state_n     = state;
        r_n         = r;
        q_n         = q;
        dvsr_n      = dvsr;
        cnt_n       = cnt;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        quotient_n  = quotient;
        remainder_n = remainder;
        dbz_n       = div_by_zero;

        // Trial subtraction as add of inverted divisor with carry-in 1
        r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
        t       = r_shift + ~{1'b0, dvsr} + (WIDTH + 1)'(1);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    dvsr_n = divisor;
                    if (divisor != '0) begin
                        state_n = RUN;
                        r_n     = '0;
                        q_n     = dividend;
                        cnt_n   = CW'(WIDTH);
                        busy_n  = 1'b1;
                    end else begin
                        state_n     = DONE;
                        done_n      = 1'b1;
                        quotient_n  = '1;
                        remainder_n = dividend;
                        dbz_n       = 1'b1;
                    end
                end else if (state == DONE) begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                q_n   = {q[WIDTH-2:0], ~t[WIDTH]};
                r_n   = t[WIDTH] ? r_shift : t;
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n     = DONE;
                    done_n      = 1'b1;
                    quotient_n  = q_n;
                    remainder_n = r_n[WIDTH-1:0];
                    dbz_n       = 1'b0;
                end else begin
                    busy_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: table vectors, handshake corner cases,
// exhaustive WIDTH=4 sweep and a random WIDTH=8 sweep, all via scoreboards.
module tb_divider_seq;

    typedef struct {
        int dvd;
        int dvs;
        int eq;
        int er;
        int edbz;
    } vec_t;

    typedef struct {
        int q;
        int r;
        int dbz;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, start8;
    logic [3:0] dividend4, divisor4, quotient4, remainder4;
    logic [7:0] dividend8, divisor8, quotient8, remainder8;
    logic       busy4, done4, dbz4, busy8, done8, dbz8;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb4[$];
    exp_t sb8[$];
    exp_t m4, m8;
    vec_t vecs[7];

    divider_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dividend(dividend4),
        .divisor(divisor4), .busy(busy4), .done(done4), .quotient(quotient4),
        .remainder(remainder4), .div_by_zero(dbz4)
    );

    divider_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dividend8),
        .divisor(divisor8), .busy(busy8), .done(done8), .quotient(quotient8),
        .remainder(remainder8), .div_by_zero(dbz8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one WIDTH=4 request in the current cycle and queue its expectation
    task automatic send4(input int dvd, input int dvs, input int eq, input int er, input int edbz);
        exp_t e;
        start4    = 1'b1;
        dividend4 = 4'(dvd);
        divisor4  = 4'(dvs);
        e.q = eq; e.r = er; e.dbz = edbz;
        e.cyc = cyc + ((dvs == 0) ? 1 : 5);
        sb4.push_back(e);
        tick();
        start4 = 1'b0;
    endtask

    task automatic send8(input int dvd, input int dvs);
        exp_t e;
        start8    = 1'b1;
        dividend8 = 8'(dvd);
        divisor8  = 8'(dvs);
        e.q   = (dvs == 0) ? 255 : dvd / dvs;
        e.r   = (dvs == 0) ? dvd : dvd % dvs;
        e.dbz = (dvs == 0) ? 1 : 0;
        e.cyc = cyc + ((dvs == 0) ? 1 : 9);
        sb8.push_back(e);
        tick();
        start8 = 1'b0;
    endtask

    task automatic wait4(input int budget);
        int n = 0;
        while (sb4.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb4.size() != 0) begin
            check("timeout4_pending", sb4.size(), 0);
            sb4.delete();
        end
    endtask

    task automatic wait8(input int budget);
        int n = 0;
        while (sb8.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb8.size() != 0) begin
            check("timeout8_pending", sb8.size(), 0);
            sb8.delete();
        end
    endtask

    task automatic check_zero4(input string tag);
        check({tag, "_busy"}, int'(busy4), 0);
        check({tag, "_done"}, int'(done4), 0);
        check({tag, "_quot"}, int'(quotient4), 0);
        check({tag, "_rem"}, int'(remainder4), 0);
        check({tag, "_dbz"}, int'(dbz4), 0);
    endtask

    // Scoreboard monitors, sampling on the falling edge
    always @(negedge clk) begin
        check("overlap4", int'(busy4 & done4), 0);
        if (done4) begin
            if (sb4.size() == 0) begin
                check("unexpected_done4", int'(done4), 0);
            end else begin
                m4 = sb4.pop_front();
                check("latency4", cyc, m4.cyc);
                check("quot4", int'(quotient4), m4.q);
                check("rem4", int'(remainder4), m4.r);
                check("dbz4", int'(dbz4), m4.dbz);
            end
        end
    end

    always @(negedge clk) begin
        check("overlap8", int'(busy8 & done8), 0);
        if (done8) begin
            if (sb8.size() == 0) begin
                check("unexpected_done8", int'(done8), 0);
            end else begin
                m8 = sb8.pop_front();
                check("latency8", cyc, m8.cyc);
                check("quot8", int'(quotient8), m8.q);
                check("rem8", int'(remainder8), m8.r);
                check("dbz8", int'(dbz8), m8.dbz);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{13, 3, 4, 1, 0};
        vecs[1] = '{15, 1, 15, 0, 0};
        vecs[2] = '{9, 10, 0, 9, 0};
        vecs[3] = '{0, 5, 0, 0, 0};
        vecs[4] = '{15, 15, 1, 0, 0};
        vecs[5] = '{7, 0, 15, 7, 1};
        vecs[6] = '{6, 2, 3, 0, 0};

        rst_n = 1'b0;
        start4 = 1'b0; dividend4 = '0; divisor4 = '0;
        start8 = 1'b0; dividend8 = '0; divisor8 = '0;
        repeat (3) tick();
        check_zero4("reset");
        check("reset8_busy", int'(busy8), 0);
        check("reset8_quot", int'(quotient8), 0);
        rst_n = 1'b1;
        tick();

        // Nominal 13/3 with busy profile over cycles 1..4
        send4(13, 3, 4, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("nominal_busy_c%0d", i), int'(busy4), 1);
            check($sformatf("nominal_done_c%0d", i), int'(done4), 0);
            tick();
        end
        wait4(10);
        tick();
        check("held_quot", int'(quotient4), 4);
        check("held_rem", int'(remainder4), 1);

        // Table-driven vectors, including divide-by-zero and its clearing
        for (int i = 0; i < 7; i++) begin
            send4(vecs[i].dvd, vecs[i].dvs, vecs[i].eq, vecs[i].er, vecs[i].edbz);
            if (vecs[i].dvs == 0) check("dbz_no_busy", int'(busy4), 0);
            wait4(10);
            tick();
        end

        // start held through RUN, operands changed to 1/1 in cycle 2
        begin
            exp_t e;
            start4 = 1'b1; dividend4 = 4'd13; divisor4 = 4'd3;
            e.q = 4; e.r = 1; e.dbz = 0; e.cyc = cyc + 5;
            sb4.push_back(e);
            tick();
            tick();
            dividend4 = 4'd1; divisor4 = 4'd1;
            tick();
            tick();
            tick();
            start4 = 1'b0;
            wait4(10);
            tick();
        end

        // Back-to-back: second start issued in the done cycle
        send4(13, 3, 4, 1, 0);
        repeat (4) tick();
        check("b2b_done_cycle", int'(done4), 1);
        send4(12, 5, 2, 2, 0);
        check("b2b_busy", int'(busy4), 1);
        wait4(10);
        tick();

        // Reset asserted at the cycle-2 edge of an in-flight division
        send4(13, 3, 4, 1, 0);
        rst_n = 1'b0;
        tick();
        check_zero4("midrst");
        sb4.delete();
        rst_n = 1'b1;
        repeat (8) tick();
        send4(13, 3, 4, 1, 0);
        wait4(10);
        tick();

        // Exhaustive WIDTH=4 sweep against the reference quotient/remainder
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                send4(a, b, (b == 0) ? 15 : a / b, (b == 0) ? a : a % b, (b == 0) ? 1 : 0);
                wait4(10);
            end
        end

        // Random WIDTH=8 sweep confirming the 9-cycle latency
        send8(200, 0);
        wait8(15);
        for (int i = 0; i < 40; i++) begin
            send8(int'($urandom_range(0, 255)), int'($urandom_range(1, 255)));
            wait8(15);
        end
        send8(255, 1);
        wait8(15);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
# divider_seq

Sequential unsigned restoring divider for the arithmetic test datapath. It computes quotient and remainder one bit per clock by trial subtraction, using the two's-complement add-with-carry-in subtraction scheme of the combinational adder/subtracter. It is the inverse operation to the shift-add multiplier path. A start/busy/done handshake lets a controller or testbench issue one division at a time.

## Interface

Parameters:
- WIDTH, 4: operand, quotient and remainder width in bits; legal range is 2 to 16.

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; sampled on the rising edge, accepted only in IDLE or DONE
- dividend  input  WIDTH  unsigned numerator; captured on acceptance
- divisor  input  WIDTH  unsigned denominator; captured on acceptance
- busy  output  1  high while an iteration is in progress
- done  output  1  one-cycle pulse marking quotient/remainder valid
- quotient  output  WIDTH  result; held stable until the next acceptance
- remainder  output  WIDTH  result; held stable until the next acceptance
- div_by_zero  output  1  set with done when the captured divisor was 0; held with the results

## Operation

- States are IDLE, RUN and DONE. Reset (rst_n low at a rising edge) forces IDLE and clears all outputs and internal registers to 0.
- IDLE or DONE with start=1: capture the operands and decide the path.
  - divisor != 0: go to RUN. Partial remainder R (WIDTH+1 bits) = 0, Q = dividend, step counter = WIDTH.
  - divisor == 0: go to DONE. quotient = all ones, remainder = dividend, div_by_zero = 1.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE. Results stay held.
- RUN performs one step per clock:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}, then Q shifts left by one.
  - T = R' + ~{0,divisor} + 1, computed at WIDTH+1 bits with carry-in 1 (subtraction).
  - If T[WIDTH] = 0: R = T and Q[0] = 1. Otherwise R = R' and Q[0] = 0.
  - The counter decrements each step.
- The step taken with counter = 1 is the last. After it, the FSM goes to DONE and loads quotient = Q and remainder = R[WIDTH-1:0], with div_by_zero = 0.
- start while in RUN is ignored: no capture and no effect on the computation.
- Operand inputs may change freely after acceptance; only the captured values are used.
- Arithmetic widths: R and T are WIDTH+1 bits, so there is no overflow. The remainder is always less than the divisor.

## Timing

- Cycle 0 is the cycle in which start is high and accepted.
- Nonzero divisor:
  - busy = 1 in cycles 1..WIDTH.
  - done = 1 in cycle WIDTH+1 only, with the results valid in that same cycle.
- Zero divisor:
  - busy never asserts.
  - done = 1 in cycle 1, with div_by_zero = 1.
- busy and done are never high together.
- Back-to-back operation: start high in the done cycle is accepted. The next division's busy begins the following cycle, giving a throughput of one division per WIDTH+1 cycles.
- Results change only at the edge that raises done, or on reset.
- rst_n low at any edge, including mid-RUN: the next cycle is IDLE with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. The interrupted division produces no done.
- All outputs are registered, with no combinational path from input to output.

## Test plan

- Nominal: WIDTH=4, dividend=13, divisor=3, start pulsed in cycle 0 -> busy high in cycles 1-4; done high in cycle 5 only, with quotient=4, remainder=1, div_by_zero=0.
- Edge values: 15/1 -> q=15, r=0. 9/10 -> q=0, r=9. 0/5 -> q=0, r=0. 15/15 -> q=1, r=0. Each reports done in cycle 5.
- Divide by zero: 7/0 -> done in cycle 1, quotient=15, remainder=7, div_by_zero=1, busy never high. A following 6/2 returns q=3, r=0 with div_by_zero cleared.
- Handshake robustness:
  - start held high through RUN with operands changed to 1/1 in cycle 2 -> the original 13/3 result is unaffected.
  - start high in the done cycle with 12/5 -> second done exactly 5 cycles later with q=2, r=2.
- Reset mid-operation: rst_n low at the cycle-2 edge of 13/3 -> all outputs 0 next cycle, no done pulse. A new 13/3 then completes normally.
- Exhaustive self-check: all 256 operand pairs at WIDTH=4 against dividend = q*divisor + r with r < divisor (zero-divisor rule applied). Repeat one random sweep at WIDTH=8 to confirm the latency of 9 cycles.
